// File: rtl/vga_pkg.sv
// Shared 640x480 VGA timing constants, lock-state encoding and counter helpers
// for the VGA receive path.
package vga_pkg;

    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BACK   = 48;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FRONT  = 16;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BACK   = 33;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FRONT  = 10;

    localparam int unsigned HC_W    = 12;
    localparam int unsigned VC_W    = 10;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned COLOR_W = 8;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        VERIFY  = 2'd2,
        LOCKED  = 2'd3
    } lock_state_e;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    function automatic logic [HC_W-1:0] hc_sat_inc(input logic [HC_W-1:0] v);
        return (v == '1) ? v : v + HC_W'(1);
    endfunction

endpackage

// File: rtl/vga_period_meter.sv
// Edge-to-edge period counter: counts inc pulses between evt pulses, saturating,
// and flags when the period just completed differs from a reference.
module vga_period_meter #(
    parameter int unsigned W = 12
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         evt,
    input  logic [W-1:0] ref_period,
    output logic [W-1:0] period,
    output logic [W-1:0] period_c,
    output logic         mismatch_c
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_inc;

    // the increment coinciding with evt belongs to the period that evt closes
    always_comb begin
        cnt_inc    = (inc && (cnt != CNT_MAX)) ? cnt + W'(1) : cnt;
        period_c   = cnt_inc;
        mismatch_c = evt && (cnt_inc != ref_period);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            period <= '0;
        end else if (evt) begin
            cnt    <= '0;
            period <= cnt_inc;
        end else begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/vga_frame_capture.sv
// VGA receiver: recovers pixel coordinates from hsync/vsync, measures line and
// frame periods and qualifies the pixel stream with a timing-lock FSM.
module vga_frame_capture #(
    parameter int unsigned H_BACK      = vga_pkg::H_BACK,
    parameter int unsigned H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int unsigned V_BACK      = vga_pkg::V_BACK,
    parameter int unsigned V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned TIMEOUT     = 4095
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic [7:0]  R,
    input  logic [7:0]  G,
    input  logic [7:0]  B,
    output logic        pixel_valid,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic [7:0]  pix_R,
    output logic [7:0]  pix_G,
    output logic [7:0]  pix_B,
    output logic        frame_start,
    output logic        locked,
    output logic [11:0] h_period,
    output logic [9:0]  v_period
);

    import vga_pkg::*;

    localparam logic [HC_W-1:0] HC_MAX   = '1;
    localparam logic [VC_W-1:0] VC_MAX   = '1;
    localparam logic [HC_W-1:0] H_LO     = HC_W'(H_BACK);
    localparam logic [HC_W-1:0] H_HI     = HC_W'(H_BACK + H_ACTIVE);
    localparam logic [VC_W-1:0] V_LO     = VC_W'(V_BACK);
    localparam logic [VC_W-1:0] V_HI     = VC_W'(V_BACK + V_ACTIVE);
    localparam logic [HC_W-1:0] IDLE_LIM = HC_W'(TIMEOUT - 1);
    localparam int unsigned     MC_W     = $clog2(LOCK_FRAMES + 1);
    localparam logic [MC_W-1:0] MC_TARGET = MC_W'(LOCK_FRAMES);

    // stage 1: input registers; stage 2 compares against the previous sample
    logic hs_s1, vs_s1, hs_s2, vs_s2;
    rgb_t rgb_s1;

    always_ff @(posedge clock) begin
        if (reset) begin
            hs_s1  <= 1'b0;
            vs_s1  <= 1'b0;
            hs_s2  <= 1'b0;
            vs_s2  <= 1'b0;
            rgb_s1 <= '0;
        end else begin
            hs_s1  <= vga_hsync;
            vs_s1  <= vga_vsync;
            hs_s2  <= hs_s1;
            vs_s2  <= vs_s1;
            rgb_s1 <= {R, G, B};
        end
    end

    logic hs_rise, hs_fall, vs_rise, vs_fall;

    always_comb begin
        hs_rise = hs_s1 & ~hs_s2;
        hs_fall = ~hs_s1 & hs_s2;
        vs_rise = vs_s1 & ~vs_s2;
        vs_fall = ~vs_s1 & vs_s2;
    end

    // position counters; the _c values describe the stage-1 sample
    logic [HC_W-1:0]    h_cnt, h_cnt_c, idle_cnt, idle_cnt_c;
    logic [VC_W-1:0]    v_cnt, v_cnt_c;
    logic               v_pending, v_pending_c;
    logic               timeout_c, h_sat_c, col_act_c, row_act_c, valid_c;
    logic [COORD_W-1:0] x_c, y_c;
    lock_state_e        state;

    always_comb begin
        h_cnt_c     = hs_rise ? '0 : hc_sat_inc(h_cnt);
        v_cnt_c     = v_cnt;
        v_pending_c = v_pending | vs_rise;
        if (hs_rise) begin
            if (v_pending_c) begin
                v_cnt_c = '0;
            end else if (v_cnt != VC_MAX) begin
                v_cnt_c = v_cnt + VC_W'(1);
            end
            v_pending_c = 1'b0;
        end
        idle_cnt_c = (hs_rise | hs_fall) ? '0 : hc_sat_inc(idle_cnt);
        timeout_c  = !(hs_rise | hs_fall) && (idle_cnt == IDLE_LIM);
        h_sat_c    = (h_cnt != HC_MAX) && (h_cnt_c == HC_MAX);
        col_act_c  = (h_cnt_c >= H_LO) && (h_cnt_c < H_HI);
        row_act_c  = (v_cnt_c >= V_LO) && (v_cnt_c < V_HI);
        x_c        = COORD_W'(h_cnt_c - H_LO);
        y_c        = COORD_W'(v_cnt_c - V_LO);
        valid_c    = (state == LOCKED) && col_act_c && row_act_c;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            v_pending <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            h_cnt     <= h_cnt_c;
            v_cnt     <= v_cnt_c;
            v_pending <= v_pending_c;
            idle_cnt  <= idle_cnt_c;
        end
    end

    // line period in clocks, frame period in lines
    logic [HC_W-1:0] h_ref, h_new_c;
    logic [VC_W-1:0] v_ref, v_new_c;
    logic            h_mis_c, v_mis_c;

    vga_period_meter #(.W(HC_W)) u_line_meter (
        .clock      (clock),
        .reset      (reset),
        .inc        (1'b1),
        .evt        (hs_fall),
        .ref_period (h_ref),
        .period     (h_period),
        .period_c   (h_new_c),
        .mismatch_c (h_mis_c)
    );

    vga_period_meter #(.W(VC_W)) u_frame_meter (
        .clock      (clock),
        .reset      (reset),
        .inc        (hs_fall),
        .evt        (vs_fall),
        .ref_period (v_ref),
        .period     (v_period),
        .period_c   (v_new_c),
        .mismatch_c (v_mis_c)
    );

    // armed: a complete frame is being measured; need_ref: next line sets h_ref
    logic [MC_W-1:0] match_cnt;
    logic            line_bad, need_ref, armed;
    logic            line_mis_c, line_err_c;

    always_comb begin
        line_mis_c = hs_fall && !need_ref && h_mis_c;
        line_err_c = line_bad || line_mis_c;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            h_ref     <= '0;
            v_ref     <= '0;
            match_cnt <= '0;
            line_bad  <= 1'b0;
            need_ref  <= 1'b0;
            armed     <= 1'b0;
        end else if (timeout_c || h_sat_c) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            match_cnt <= '0;
            line_bad  <= 1'b0;
            need_ref  <= 1'b0;
            armed     <= 1'b0;
        end else begin
            case (state)
                SEARCH: begin
                    if (vs_fall) begin
                        state    <= MEASURE;
                        armed    <= 1'b1;
                        need_ref <= 1'b1;
                        line_bad <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (!armed) begin
                        if (vs_fall) begin
                            armed    <= 1'b1;
                            need_ref <= 1'b1;
                            line_bad <= 1'b0;
                        end
                    end else if (vs_fall) begin
                        line_bad <= 1'b0;
                        if (line_err_c || need_ref) begin
                            need_ref <= 1'b1;
                        end else begin
                            v_ref     <= v_new_c;
                            match_cnt <= MC_W'(1);
                            state     <= (LOCK_FRAMES > 1) ? VERIFY : LOCKED;
                            locked    <= (LOCK_FRAMES <= 1);
                        end
                    end else if (hs_fall) begin
                        if (need_ref) begin
                            h_ref    <= h_new_c;
                            need_ref <= 1'b0;
                        end else if (h_mis_c) begin
                            line_bad <= 1'b1;
                        end
                    end
                end
                VERIFY: begin
                    if (vs_fall) begin
                        line_bad <= 1'b0;
                        if (!line_err_c && !v_mis_c) begin
                            match_cnt <= match_cnt + MC_W'(1);
                            if (match_cnt + MC_W'(1) == MC_TARGET) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            state     <= MEASURE;
                            armed     <= 1'b1;
                            need_ref  <= 1'b1;
                            v_ref     <= v_new_c;
                            match_cnt <= '0;
                        end
                    end else if (line_mis_c) begin
                        line_bad <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (line_mis_c || (vs_fall && v_mis_c)) begin
                        state     <= MEASURE;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        line_bad  <= 1'b0;
                        armed     <= vs_fall;
                        need_ref  <= vs_fall;
                        if (vs_fall) begin
                            v_ref <= v_new_c;
                        end
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // output stage; coordinates and colour hold while no pixel is valid
    always_ff @(posedge clock) begin
        if (reset) begin
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            x_pos       <= '0;
            y_pos       <= '0;
            pix_R       <= '0;
            pix_G       <= '0;
            pix_B       <= '0;
        end else begin
            pixel_valid <= valid_c;
            frame_start <= valid_c && (x_c == '0) && (y_c == '0);
            if (valid_c) begin
                x_pos <= x_c;
                y_pos <= y_c;
                pix_R <= rgb_s1.r;
                pix_G <= rgb_s1.g;
                pix_B <= rgb_s1.b;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture using a reduced 28x12 raster so that
// lock, relock, timeout and reset scenarios fit in a short run.
module tb_vga_frame_capture;

    localparam int HS = 4;
    localparam int HB = 4;
    localparam int HA = 16;
    localparam int HT = 28;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int VA = 6;
    localparam int VT = 12;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        vga_hsync = 1'b1;
    logic        vga_vsync = 1'b1;
    logic [7:0]  R = 8'h0;
    logic [7:0]  G = 8'h0;
    logic [7:0]  B = 8'h0;
    logic        pixel_valid;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic [7:0]  pix_R;
    logic [7:0]  pix_G;
    logic [7:0]  pix_B;
    logic        frame_start;
    logic        locked;
    logic [11:0] h_period;
    logic [9:0]  v_period;

    vga_frame_capture #(
        .H_BACK      (HB),
        .H_ACTIVE    (HA),
        .V_BACK      (VB),
        .V_ACTIVE    (VA),
        .LOCK_FRAMES (2),
        .TIMEOUT     (4095)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .R           (R),
        .G           (G),
        .B           (B),
        .pixel_valid (pixel_valid),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .pix_R       (pix_R),
        .pix_G       (pix_G),
        .pix_B       (pix_B),
        .frame_start (frame_start),
        .locked      (locked),
        .h_period    (h_period),
        .v_period    (v_period)
    );

    always #20 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // passive monitor, sampled on the falling edge
    int   valid_tot = 0;
    int   fs_tot = 0;
    int   pix_err = 0;
    int   fs_cyc = 0;
    int   ff_x = -1;
    int   ff_y = -1;
    int   lx = -1;
    int   ly = -1;
    int   last_valid_cyc = -1000;
    int   rise_cyc = 0;
    int   fall_cyc = 0;
    logic prev_locked = 1'b0;

    always @(negedge clock) begin
        if (pixel_valid) begin
            valid_tot++;
            if (pix_R !== x_pos[7:0] || pix_G !== y_pos[7:0] || pix_B !== {6'b0, x_pos[9:8]})
                pix_err++;
            if (cyc - last_valid_cyc > 50) begin
                ff_x = int'(x_pos);
                ff_y = int'(y_pos);
            end
            last_valid_cyc = cyc;
            lx = int'(x_pos);
            ly = int'(y_pos);
        end
        if (frame_start) begin
            fs_tot++;
            fs_cyc = cyc;
        end
        if (locked && !prev_locked) rise_cyc = cyc;
        if (!locked && prev_locked) fall_cyc = cyc;
        prev_locked = locked;
    end

    int frame_cyc = 0;
    int px0_cyc = 0;
    int long_end_cyc = 0;
    int base_v = 0;
    int base_f = 0;

    task automatic clk1(input logic hs, input logic vs, input logic [7:0] cr,
                        input logic [7:0] cg, input logic [7:0] cb);
        vga_hsync = hs;
        vga_vsync = vs;
        R = cr;
        G = cg;
        B = cb;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) clk1(1'b1, 1'b1, 8'h5A, 8'h5A, 8'h5A);
    endtask

    // pixel-ID raster: R=x[7:0], G=y[7:0], B=x[9:8]; long_idx line gets one extra clock
    task automatic send_frame(input int nlines, input int long_idx);
        frame_cyc = cyc;
        for (int l = 0; l < nlines; l++) begin
            int len;
            len = (l == long_idx) ? HT + 1 : HT;
            if (long_idx >= 0 && l == long_idx + 1) long_end_cyc = cyc;
            for (int c = 0; c < len; c++) begin
                logic [9:0] x;
                logic [9:0] y;
                logic       act;
                act = (c >= HS + HB) && (c < HS + HB + HA) && (l >= VS + VB) && (l < VS + VB + VA);
                x = 10'(c - (HS + HB));
                y = 10'(l - (VS + VB));
                if (act && x == 10'd0 && y == 10'd0) px0_cyc = cyc;
                if (act)
                    clk1(c >= HS, l >= VS, x[7:0], y[7:0], {6'b0, x[9:8]});
                else
                    clk1(c >= HS, l >= VS, 8'hA5, 8'h3C, 8'hFF);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, int'(pixel_valid), 0);
        check({tag, "_x"}, int'(x_pos), 0);
        check({tag, "_y"}, int'(y_pos), 0);
        check({tag, "_R"}, int'(pix_R), 0);
        check({tag, "_G"}, int'(pix_G), 0);
        check({tag, "_B"}, int'(pix_B), 0);
        check({tag, "_fs"}, int'(frame_start), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_hper"}, int'(h_period), 0);
        check({tag, "_vper"}, int'(v_period), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idle(3);
        check_all_zero("rst");
        reset = 1'b0;
        idle(10);

        // clean lock from reset: locked rises at the 3rd vsync fall
        send_frame(VT, -1);
        send_frame(VT, -1);
        check("lock_pre3", int'(locked), 0);
        base_v = valid_tot;
        base_f = fs_tot;
        send_frame(VT, -1);
        check("lock_rise_cyc", rise_cyc, frame_cyc + 2);
        check("locked", int'(locked), 1);
        check("h_period", int'(h_period), HT);
        check("v_period", int'(v_period), VT);
        check("valid_per_frame", valid_tot - base_v, HA * VA);
        check("fs_per_frame", fs_tot - base_f, 1);
        check("fs_latency", fs_cyc, px0_cyc + 2);
        check("first_x", ff_x, 0);
        check("first_y", ff_y, 0);
        check("last_x", lx, HA - 1);
        check("last_y", ly, VA - 1);

        // one 29-clock line while locked
        send_frame(VT, 6);
        check("long_unlock", int'(locked), 0);
        check("long_fall_cyc", fall_cyc, long_end_cyc + 2);
        send_frame(VT, -1);
        send_frame(VT, -1);
        check("long_pre_relock", int'(locked), 0);
        send_frame(VT, -1);
        check("long_relock", int'(locked), 1);
        check("long_relock_cyc", rise_cyc, frame_cyc + 2);
        check("pix_err_a", pix_err, 0);

        // syncs held high: lock drops after 4095 edgeless samples
        idle(4000);
        check("hold_still_locked", int'(locked), 1);
        base_v = valid_tot;
        idle(1000);
        check("timeout_unlock", int'(locked), 0);
        check("timeout_cyc", fall_cyc, frame_cyc + (VT - 1) * HT + HS + 4095 + 2);
        check("timeout_no_valid", valid_tot - base_v, 0);
        send_frame(VT, -1);
        send_frame(VT, -1);
        check("to_pre_relock", int'(locked), 0);
        send_frame(VT, -1);
        check("to_relock", int'(locked), 1);

        // reset mid-frame while locked
        send_frame(6, -1);
        reset = 1'b1;
        idle(1);
        check_all_zero("midrst");
        reset = 1'b0;
        idle(10);
        send_frame(VT, -1);
        send_frame(VT, -1);
        check("rst_pre_relock", int'(locked), 0);
        send_frame(VT, -1);
        check("rst_relock", int'(locked), 1);
        check("rst_relock_cyc", rise_cyc, frame_cyc + 2);

        // frames shortened by one line
        send_frame(VT - 1, -1);
        check("short_still_locked", int'(locked), 1);
        send_frame(VT - 1, -1);
        check("short_unlock", int'(locked), 0);
        check("short_fall_cyc", fall_cyc, frame_cyc + 2);
        check("short_v_period", int'(v_period), VT - 1);
        send_frame(VT - 1, -1);
        check("short_pre_relock", int'(locked), 0);
        send_frame(VT - 1, -1);
        check("short_relock", int'(locked), 1);
        check("short_relock_cyc", rise_cyc, frame_cyc + 2);
        check("pix_err_b", pix_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
